// File: rtl/multdiv_if.sv
// Execute-stage <-> multiply/divide unit bus: operands, start strobes and the
// registered result, exception flag and completion pulse.
interface multdiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring), WIDTH steps per op.
// Optional MULTDIV_DIV0_EARLY_EN: divide by zero completes one edge after start.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clock,
  input  logic       reset,
  multdiv_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q, neg_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 exc_q, exc_d;
  logic                 rdy_q, rdy_d;

  logic [WIDTH-1:0]     op_a, op_b, mag_a, mag_b, rem_sh, quo_s;
  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH-1:0]   acc_sh, prod;
  logic                 start, last_iter;

  assign op_a      = bus.data_operandA;
  assign op_b      = bus.data_operandB;
  assign mag_a     = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
  assign mag_b     = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
  assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
  assign last_iter = (cnt_q == CNT_W'(WIDTH));

  // Multiply: acc = {partial product, remaining multiplier bits}; divide: acc = {remainder, quotient}.
  assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign acc_sh  = {acc_q[2*WIDTH-2:0], 1'b0};
  assign rem_sh  = acc_sh[2*WIDTH-1:WIDTH];
  assign prod    = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_s   = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    // A start strobe wins in every state, silently aborting any running op.
    if (start) begin
      neg_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
      div0_d = (op_b == '0);
      cnt_d  = '0;
      if (bus.ctrl_MULT) begin
        state_d = S_MULT;
        mcand_d = mag_a;
        acc_d   = {{WIDTH{1'b0}}, mag_b};
      end else begin
        state_d = S_DIV;
        mcand_d = mag_b;
        acc_d   = {{WIDTH{1'b0}}, mag_a};
`ifdef MULTDIV_DIV0_EARLY_EN
        // Preloading the counter makes the very next edge the completion edge.
        if (op_b == '0) cnt_d = CNT_W'(WIDTH);
`endif
      end
    end else begin
      case (state_q)
        S_MULT: begin
          if (last_iter) begin
            result_d = prod[WIDTH-1:0];
            exc_d    = (prod[2*WIDTH-1:WIDTH-1] != '0) && (prod[2*WIDTH-1:WIDTH-1] != '1);
            rdy_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            acc_d = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DIV: begin
          if (last_iter) begin
            // Only an unsigned-positive quotient with the top bit set (MIN / -1) overflows.
            result_d = div0_q ? '0 : quo_s;
            exc_d    = div0_q | (~neg_q & acc_q[WIDTH-1]);
            rdy_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            acc_d = (rem_sh >= mcand_q) ? {rem_sh - mcand_q, acc_sh[WIDTH-1:1], 1'b1} : acc_sh;
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule
